// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared types and constants for the RV32IM instruction encoder.
//   opcode_t    : RV32IM major opcodes accepted by the encoder
//   func_code_t : ALU funct3 codes (REGREG / REGIMM)
//   br_code_t   : branch funct3 codes
//   wrd_size_t  : load/store width funct3 codes
//   enc_state_t : load-framing FSM states
//   NOP_INSTR   : canonical NOP (addi x0, x0, 0)
package instr_enc_pkg;

  typedef enum logic [6:0] {
    REGREG = 7'b0110011,
    REGIMM = 7'b0010011,
    LD     = 7'b0000011,
    STR    = 7'b0100011,
    BR     = 7'b1100011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    AUIPC  = 7'b0010111,
    LUI    = 7'b0110111
  } opcode_t;

  typedef enum logic [2:0] {
    F_ADD_SUB = 3'b000,
    F_SLL     = 3'b001,
    F_SLT     = 3'b010,
    F_SLTU    = 3'b011,
    F_XOR     = 3'b100,
    F_SRL_SRA = 3'b101,
    F_OR      = 3'b110,
    F_AND     = 3'b111
  } func_code_t;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_code_t;

  typedef enum logic [2:0] {
    SZ_BYTE   = 3'b000,
    SZ_HALF   = 3'b001,
    SZ_WORD   = 3'b010,
    SZ_BYTE_U = 3'b100,
    SZ_HALF_U = 3'b101
  } wrd_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } enc_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when v is representable as a 'bits'-wide two's-complement value:
  // everything from bit (bits-1) upward must be a copy of the sign.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// instr_pack: purely combinational field-record -> RV32IM instruction word packer.
// Ports:
//   op, rd, rs1, rs2, f3, sub, mul, imm : decoded field record
//   instr : packed 32-bit word (NOP_INSTR for unknown opcodes or failed checks)
//   bad   : record failed range/alignment checks
// Build option ENC_CHECK_EN: enables immediate range/alignment and opcode
// checks; when undefined, fields are truncated silently and bad is tied 0.
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  f3,
  input  logic        sub,
  input  logic        mul,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        bad
);

  logic [31:0] raw;
  logic        is_shift;

  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Field placement per instruction format; unknown opcodes collapse to NOP.
  always_comb begin
    raw = NOP_INSTR;
    case (op)
      REGREG: raw = {1'b0, sub, 4'b0000, mul, rs2, rs1, f3, rd, op};
      REGIMM: begin
        // Shift-immediates carry only a 5-bit shamt; bit 30 selects SRAI.
        if (is_shift) begin
          raw = {1'b0, sub, 5'b00000, imm[4:0], rs1, f3, rd, op};
        end else begin
          raw = {imm[11:0], rs1, f3, rd, op};
        end
      end
      LD:          raw = {imm[11:0], rs1, f3, rd, op};
      JALR:        raw = {imm[11:0], rs1, 3'b000, rd, op};
      STR:         raw = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      BR:          raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      JAL:         raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      LUI, AUIPC:  raw = {imm[31:12], rd, op};
      default:     raw = NOP_INSTR;
    endcase
  end

`ifdef ENC_CHECK_EN
  // Flag immediates that would not survive truncation into their field.
  always_comb begin
    bad = 1'b0;
    case (op)
      REGREG: bad = 1'b0;
      REGIMM: begin
        if (is_shift) begin
          bad = (imm[31:5] != 27'd0);
        end else begin
          bad = !fits_signed(imm, 32'd12);
        end
      end
      LD, JALR, STR: bad = !fits_signed(imm, 32'd12);
      BR:            bad = !fits_signed(imm, 32'd13) || imm[0];
      JAL:           bad = !fits_signed(imm, 32'd21) || imm[0];
      LUI, AUIPC:    bad = (imm[11:0] != 12'd0);
      default:       bad = 1'b1;
    endcase
  end

  assign instr = bad ? NOP_INSTR : raw;
`else
  assign bad   = 1'b0;
  assign instr = raw;
`endif

endmodule

// File: rtl/instr_enc.sv
// instr_enc: RV32IM instruction encoder between program loader and imem.
// Accepts field records on a valid/ready stream, emits packed words with
// sequential byte addresses starting at BASE_ADDR. IDLE/RUN/DRAIN FSM frames
// each load: start opens it, the in_last record closes it, done pulses once
// after the final word is taken.
// Ports:
//   clk, rst (sync, active high), start
//   in_valid/in_ready + in_op, in_rd, in_rs1, in_rs2, in_f3, in_sub, in_mul, in_imm, in_last
//   out_valid/out_ready + out_instr, out_addr
//   busy, done, count, err
// Build option ENC_CHECK_EN: enables encode checks inside instr_pack; err is
// then sticky until start/rst. Without it err stays 0.
module instr_enc
  import instr_enc_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_f3,
  input  logic              in_sub,
  input  logic              in_mul,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              err
);

  enc_state_t  state, state_nxt;
  logic        accept, out_hs;
  logic [31:0] pack_instr;
  logic        pack_bad;

  assign accept = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  instr_pack u_pack (
    .op    (in_op),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .f3    (in_f3),
    .sub   (in_sub),
    .mul   (in_mul),
    .imm   (in_imm),
    .instr (pack_instr),
    .bad   (pack_bad)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (accept && in_last) state_nxt = DRAIN;
        else                   state_nxt = RUN;
      end
      DRAIN: begin
        if (out_hs) state_nxt = IDLE;
        else        state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept only in RUN while the output slot is free or draining.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
      RUN: begin
        in_ready = ~out_valid | out_ready;
        busy     = 1'b1;
      end
      DRAIN: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Output word register, address/count tracking, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0000_0000;
      out_addr  <= BASE_ADDR;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= (state == DRAIN) && out_hs;
      if ((state == IDLE) && start) begin
        out_addr <= BASE_ADDR;
        count    <= '0;
        err      <= 1'b0;
      end else begin
        if (out_hs) begin
          out_addr <= out_addr + ADDR_W'(32'd4);
          count    <= count + CNT_W'(1'b1);
        end
        // A new word may replace the one leaving on the same edge.
        if (accept) begin
          out_valid <= 1'b1;
          out_instr <= pack_instr;
          err       <= err | pack_bad;
        end else if (out_hs) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_enc.sv
module tb_instr_enc;
  import instr_enc_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [31:0] BASE   = 32'h0000_1000;

`ifdef ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk, rst, start;
  logic              in_valid, in_ready;
  logic [6:0]        in_op;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_f3;
  logic              in_sub, in_mul, in_last;
  logic [31:0]       in_imm;
  logic              out_valid, out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              busy, done, err;
  logic [CNT_W-1:0]  count;

  instr_enc #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_f3(in_f3), .in_sub(in_sub), .in_mul(in_mul), .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int load_idx = 0;
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_addr_q[$];

  // Reference encoding written from the instruction-format tables.
  function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                          input logic [2:0] f3, input logic sub, mul, input logic [31:0] imm);
    logic [31:0] r;
    r = (32'(rs1) << 15) | (32'(rd) << 7) | 32'(op);
    case (op)
      REGREG: return r | (32'(sub) << 30) | (32'(mul) << 25) | (32'(rs2) << 20) | (32'(f3) << 12);
      REGIMM: if (f3 == 3'd1 || f3 == 3'd5) return r | (32'(sub) << 30) | ((imm & 32'h1F) << 20) | (32'(f3) << 12);
              else return r | (imm << 20) | (32'(f3) << 12);
      LD:     return r | (imm << 20) | (32'(f3) << 12);
      JALR:   return r | (imm << 20);
      STR:    return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                     | ((imm & 32'h1F) << 7) | 32'(op);
      BR:     return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                     | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
                     | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      JAL:    return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                     | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
      LUI, AUIPC: return (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    case (op)
      REGIMM: if (f3 == 3'd1 || f3 == 3'd5) return {27'd0, r[4:0]};
              else return {{20{r[11]}}, r[11:0]};
      LD, JALR, STR: return {{20{r[11]}}, r[11:0]};
      BR:  return {{19{r[12]}}, r[12:1], 1'b0};
      JAL: return {{11{r[20]}}, r[20:1], 1'b0};
      LUI, AUIPC: return {r[31:12], 12'd0};
      default: return r;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    @(posedge clk);
    #1;
    start = 1'b1;
    step();
    start = 1'b0;
    load_idx = 0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic sub, mul, input logic [31:0] imm, input logic last, input logic [31:0] expw);
    bit ok;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_f3 = f3;
    in_sub = sub; in_mul = mul; in_imm = imm; in_last = last; in_valid = 1'b1;
    exp_instr_q.push_back(expw);
    exp_addr_q.push_back(BASE + 32'(load_idx) * 32'd4);
    load_idx++;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL send_timeout: in_ready=0 for 64 cycles, required 1");
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard: pop one expected word for each output handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_instr_q.size() == 0) begin
        $display("FAIL sb_unexpected: word %h at %h, required no word", out_instr, out_addr);
      end else begin
        logic [31:0] ei, ea;
        ei = exp_instr_q.pop_front();
        ea = exp_addr_q.pop_front();
        if (out_instr !== ei) $display("FAIL sb_instr: got %h required %h", out_instr, ei);
        else passed++;
        checks++;
        if (out_addr !== ea) $display("FAIL sb_addr: got %h required %h", out_addr, ea);
        else passed++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    in_op = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_f3 = 3'd0;
    in_sub = 1'b0; in_mul = 1'b0; in_imm = 32'd0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else passed++;
    checks++; if (out_instr !== 32'd0) $display("FAIL rst_out_instr: got %h required 0", out_instr); else passed++;
    checks++; if (out_addr !== BASE) $display("FAIL rst_out_addr: got %h required %h", out_addr, BASE); else passed++;
    checks++; if (count !== 16'd0) $display("FAIL rst_count: got %0d required 0", count); else passed++;
    checks++; if ({busy, done, err, in_ready} !== 4'b0000)
      $display("FAIL rst_flags: busy/done/err/in_ready got %b required 0000", {busy, done, err, in_ready}); else passed++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    bit seen;
    out_ready = 1'b1;
    start_load();
    send(REGREG, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h002081B3);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_addr !== BASE)
      $display("FAIL latency1: valid=%b instr=%h addr=%h required 1 002081b3 %h", out_valid, out_instr, out_addr, BASE);
    else passed++;
    step();
    send(REGREG, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h407302B3);
    send(BR, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'hFE208CE3);
    send(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h0000_0800, 1'b0, 32'h001000EF);
    send(LUI, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h1234_5000, 1'b1, 32'h12345537);
    wait_done(seen);
    checks++; if (!seen) $display("FAIL vec_done: done never seen, required pulse"); else passed++;
    checks++; if (count !== 16'd5) $display("FAIL vec_count: got %0d required 5", count); else passed++;
    checks++; if (out_addr !== BASE + 32'd20) $display("FAIL vec_addr_end: got %h required %h", out_addr, BASE + 32'd20); else passed++;
  endtask

  task automatic test_encodings();
    bit seen;
    bit sends_done;
    logic [6:0] ops [0:8];
    ops = '{REGREG, REGIMM, LD, STR, BR, JAL, JALR, AUIPC, LUI};
    sends_done = 1'b0;
    start_load();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [6:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic sub, mul; logic [31:0] imm;
          op = ops[$urandom_range(0, 8)];
          rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); f3 = 3'($urandom);
          sub = 1'($urandom); mul = 1'($urandom);
          imm = gen_imm(op, f3);
          send(op, rd, rs1, rs2, f3, sub, mul, imm, (i == 39), ref_enc(op, rd, rs1, rs2, f3, sub, mul, imm));
        end
        sends_done = 1'b1;
      end
      begin
        while (!sends_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_done(seen);
    checks++; if (!seen) $display("FAIL rand_done: done never seen, required pulse"); else passed++;
    checks++; if (count !== 16'd40) $display("FAIL rand_count: got %0d required 40", count); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rand_err: got %b required 0", err); else passed++;
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [31:0] w2;
    out_ready = 1'b1;
    start_load();
    send(REGREG, 5'd1, 5'd2, 5'd3, 3'd7, 1'b0, 1'b1, 32'd0, 1'b0, ref_enc(REGREG, 5'd1, 5'd2, 5'd3, 3'd7, 1'b0, 1'b1, 32'd0));
    w2 = ref_enc(STR, 5'd0, 5'd4, 5'd9, 3'd2, 1'b0, 1'b0, 32'hFFFF_FF84);
    send(STR, 5'd0, 5'd4, 5'd9, 3'd2, 1'b0, 1'b0, 32'hFFFF_FF84, 1'b0, w2);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_instr !== w2 || out_addr !== BASE + 32'd4 || in_ready !== 1'b0)
        $display("FAIL bp_hold: valid=%b instr=%h addr=%h in_ready=%b required 1 %h %h 0",
                 out_valid, out_instr, out_addr, in_ready, w2, BASE + 32'd4);
      else passed++;
      step();
    end
    out_ready = 1'b1;
    send(LD, 5'd8, 5'd2, 5'd0, 3'd4, 1'b0, 1'b0, 32'h0000_07FF, 1'b1, ref_enc(LD, 5'd8, 5'd2, 5'd0, 3'd4, 1'b0, 1'b0, 32'h0000_07FF));
    wait_done(seen);
    checks++; if (!seen) $display("FAIL bp_done: done never seen, required pulse"); else passed++;
    checks++; if (busy !== 1'b0 || count !== 16'd3) $display("FAIL bp_end: busy=%b count=%0d required 0 3", busy, count); else passed++;
    checks++; if (out_addr !== BASE + 32'd12) $display("FAIL bp_addr: got %h required %h", out_addr, BASE + 32'd12); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL bp_done_width: done still %b, required 0", done); else passed++;
  endtask

  task automatic test_start_ignored_and_reset();
    bit seen;
    out_ready = 1'b1;
    start_load();
    send(REGIMM, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 1'b0, 32'd5, 1'b0, ref_enc(REGIMM, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 1'b0, 32'd5));
    send(REGIMM, 5'd2, 5'd3, 5'd0, 3'd5, 1'b1, 1'b0, 32'd7, 1'b0, ref_enc(REGIMM, 5'd2, 5'd3, 5'd0, 3'd5, 1'b1, 1'b0, 32'd7));
    start = 1'b1;
    step();
    start = 1'b0;
    send(JALR, 5'd1, 5'd5, 5'd0, 3'd3, 1'b0, 1'b0, 32'h10, 1'b0, ref_enc(JALR, 5'd1, 5'd5, 5'd0, 3'd3, 1'b0, 1'b0, 32'h10));
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (count !== 16'd2 || out_addr !== BASE + 32'd8 || busy !== 1'b1)
      $display("FAIL start_ignored: count=%0d addr=%h busy=%b required 2 %h 1", count, out_addr, busy, BASE + 32'd8);
    else passed++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({out_valid, busy, done, err, in_ready} !== 5'b00000 || out_instr !== 32'd0 || out_addr !== BASE || count !== 16'd0)
      $display("FAIL midrun_rst: v/b/d/e/r=%b instr=%h addr=%h count=%0d required 00000 0 %h 0",
               {out_valid, busy, done, err, in_ready}, out_instr, out_addr, count, BASE);
    else passed++;
    checks++; if (exp_instr_q.size() != 1) $display("FAIL midrun_pending: %0d words queued, required 1", exp_instr_q.size()); else passed++;
    exp_instr_q.delete();
    exp_addr_q.delete();
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL midrun_no_done: done pulsed, required none"); else passed++;
  endtask

  task automatic test_check();
    bit seen;
    logic exp_err;
    logic [31:0] w_bad;
    exp_err = CHK;
    w_bad = CHK ? NOP_INSTR : ref_enc(BR, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 1'b0, 32'd5);
    out_ready = 1'b1;
    start_load();
    send(BR, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 1'b0, 32'd5, 1'b0, w_bad);
    @(negedge clk);
    checks++; if (err !== exp_err) $display("FAIL chk_err_set: got %b required %b", err, exp_err); else passed++;
    step();
    send(REGREG, 5'd4, 5'd4, 5'd4, 3'd1, 1'b0, 1'b0, 32'd0, 1'b1, ref_enc(REGREG, 5'd4, 5'd4, 5'd4, 3'd1, 1'b0, 1'b0, 32'd0));
    wait_done(seen);
    checks++; if (!seen || err !== exp_err) $display("FAIL chk_err_sticky: done_seen=%b err=%b required 1 %b", seen, err, exp_err); else passed++;
    start_load();
    @(negedge clk);
    checks++; if (err !== 1'b0) $display("FAIL chk_err_clear: got %b required 0", err); else passed++;
    step();
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, NOP_INSTR);
    wait_done(seen);
    checks++; if (!seen || err !== exp_err) $display("FAIL chk_unknown_op: done_seen=%b err=%b required 1 %b", seen, err, exp_err); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_vectors();
    test_encodings();
    test_backpressure();
    test_start_ignored_and_reset();
    test_check();
    repeat (3) step();
    checks++; if (exp_instr_q.size() != 0) $display("FAIL sb_leftover: %0d words never emitted, required 0", exp_instr_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
